dram_responder: RTL and testbench

Data-memory responder on the far side of the controller's DRAM strobe interface. It samples `DRAM_read`/`DRAM_write` with the address from MAR and write data from MDR, performs the access after a fixed, parameterised latency, and signals completion with a one-cycle `ready` pulse and registered `rdata`. It owns the data-memory array, enforces one outstanding access, and flags protocol violations (overrun, conflicting strobes) with sticky error bits.

---
 rtl/dram_pkg.sv | 17 +
 rtl/dram_responder_if.sv | 40 ++++
 rtl/dram_array.sv | 22 ++
 rtl/dram_responder.sv | 143 ++++++++++++++
 tb/tb_dram_responder.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/dram_pkg.sv
// Shared types and widths for the DRAM responder slice.
package dram_pkg;

  localparam int unsigned DRAM_LAT_W = 4;
  localparam int unsigned DRAM_CNT_W = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } op_e;

endpackage

// File: rtl/dram_responder_if.sv
// Strobe/data bus between controller (master) and DRAM responder (slave).
// Counter signals exist only when DRAM_STATS_EN is defined.
interface dram_responder_if
  import dram_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) ();

  logic              DRAM_read;
  logic              DRAM_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;
  logic              err_overrun;
  logic              err_conflict;
`ifdef DRAM_STATS_EN
  logic [DRAM_CNT_W-1:0] rd_count;
  logic [DRAM_CNT_W-1:0] wr_count;
`endif

  modport master (
    output DRAM_read, DRAM_write, addr, wdata,
    input  rdata, ready, busy, err_overrun, err_conflict
`ifdef DRAM_STATS_EN
    , input rd_count, wr_count
`endif
  );

  modport slave (
    input  DRAM_read, DRAM_write, addr, wdata,
    output rdata, ready, busy, err_overrun, err_conflict
`ifdef DRAM_STATS_EN
    , output rd_count, wr_count
`endif
  );

endinterface

// File: rtl/dram_array.sv
// Single-port synchronous data-memory array with registered read.
module dram_array #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/dram_responder.sv
// Data-memory responder: one outstanding access, fixed latency, sticky protocol errors.
// Optional read/write completion counters under DRAM_STATS_EN.
module dram_responder
  import dram_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  dram_responder_if.slave  bus
);

  state_e                state_q, state_d;
  logic [DRAM_LAT_W-1:0] lat_q, lat_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  op_e                   op_q, op_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  ovr_q, ovr_d;
  logic                  cnf_q, cnf_d;
  logic                  we_c;
  logic [ADDR_W-1:0]     ram_addr_c;
  logic [DATA_W-1:0]     ram_dout;
`ifdef DRAM_STATS_EN
  logic [DRAM_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [DRAM_CNT_W-1:0] wr_cnt_q, wr_cnt_d;
`endif

  // Read is launched one edge ahead of completion so rdata lands on the completion edge.
  assign ram_addr_c = (state_q == IDLE) ? bus.addr : addr_q;

  dram_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clk  (clk),
    .we   (we_c),
    .addr (ram_addr_c),
    .din  (wdata_q),
    .dout (ram_dout)
  );

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    busy_d  = busy_q;
    ovr_d   = ovr_q;
    cnf_d   = cnf_q;
    we_c    = 1'b0;
`ifdef DRAM_STATS_EN
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.DRAM_read && bus.DRAM_write) begin
          cnf_d = 1'b1;
        end else if (bus.DRAM_read || bus.DRAM_write) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          op_d    = bus.DRAM_write ? WR : RD;
          lat_d   = DRAM_LAT_W'(LATENCY - 1);
          busy_d  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.DRAM_read || bus.DRAM_write) ovr_d = 1'b1;
        if (lat_q != '0) begin
          lat_d = DRAM_LAT_W'(lat_q - 1'b1);
        end else begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
          if (op_q == WR) begin
            // A reset on the completion edge must not commit the write.
            we_c = !rst;
`ifdef DRAM_STATS_EN
            if (wr_cnt_q != '1) wr_cnt_d = DRAM_CNT_W'(wr_cnt_q + 1'b1);
`endif
          end else begin
            rdata_d = ram_dout;
`ifdef DRAM_STATS_EN
            if (rd_cnt_q != '1) rd_cnt_d = DRAM_CNT_W'(rd_cnt_q + 1'b1);
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_q     <= RD;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      cnf_q    <= 1'b0;
`ifdef DRAM_STATS_EN
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      op_q     <= op_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
      cnf_q    <= cnf_d;
`ifdef DRAM_STATS_EN
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
`endif
    end
  end

  assign bus.rdata        = rdata_q;
  assign bus.ready        = ready_q;
  assign bus.busy         = busy_q;
  assign bus.err_overrun  = ovr_q;
  assign bus.err_conflict = cnf_q;
`ifdef DRAM_STATS_EN
  assign bus.rd_count     = rd_cnt_q;
  assign bus.wr_count     = wr_cnt_q;
`endif

endmodule

// File: tb/tb_dram_responder.sv
// Scoreboard bench for dram_responder at LATENCY=3; counter checks under DRAM_STATS_EN.
module tb_dram_responder;

  localparam int unsigned LAT = 3;

  typedef struct {
    logic        is_rd;
    logic [15:0] data;
    int          edge_no;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   edge_no = 0;
  exp_t sbq[$];
  logic [15:0] model [int];

  dram_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  dram_responder #(.ADDR_W(16), .DATA_W(16), .LATENCY(LAT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_no <= edge_no + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every ready pulse must match the oldest expected completion.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && bus.ready === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("spurious_ready", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("ready_edge", 32'(edge_no), 32'(e.edge_no + int'(LAT)));
        if (e.is_rd) chk("rdata", 32'(bus.rdata), 32'(e.data));
      end
    end
  end

  // Called at a negedge; returns just after a negedge.
  task automatic access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    bus.DRAM_read  = rd;
    bus.DRAM_write = wr;
    bus.addr       = a;
    bus.wdata      = d;
    if (rd ^ wr) begin
      sbq.push_back('{rd, rd ? model[int'(a)] : 16'h0000, edge_no + 1});
      if (wr) model[int'(a)] = d;
    end
    @(posedge clk);
    @(negedge clk);
    bus.DRAM_read  = 1'b0;
    bus.DRAM_write = 1'b0;
    if (rd ^ wr) begin
      for (int k = 0; k < int'(LAT); k++) begin
        chk("busy_high", 32'(bus.busy), 32'd1);
        @(negedge clk);
      end
      chk("busy_low", 32'(bus.busy), 32'd0);
      #1;
      chk("ready_seen", 32'(sbq.size()), 32'd0);
    end else begin
      chk("conflict_busy", 32'(bus.busy), 32'd0);
      chk("conflict_flag", 32'(bus.err_conflict), 32'd1);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_overrun", 32'(bus.err_overrun), 32'd0);
    chk("rst_conflict", 32'(bus.err_conflict), 32'd0);
`ifdef DRAM_STATS_EN
    chk("rst_rd_count", 32'(bus.rd_count), 32'd0);
    chk("rst_wr_count", 32'(bus.wr_count), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.DRAM_read  = 1'b0;
    bus.DRAM_write = 1'b0;
    bus.addr       = '0;
    bus.wdata      = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_state();

    // Basic write then read
    access(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    access(1'b1, 1'b0, 16'h0010, 16'h0000);

    // Overrun: second read strobe two edges after accept is dropped
    bus.DRAM_read = 1'b1;
    bus.addr      = 16'h0010;
    sbq.push_back('{1'b1, model[16'h0010], edge_no + 1});
    @(posedge clk); @(negedge clk);
    bus.DRAM_read = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.DRAM_read = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.DRAM_read = 1'b0;
    chk("overrun_flag", 32'(bus.err_overrun), 32'd1);
    chk("overrun_busy", 32'(bus.busy), 32'd1);
    repeat (4) @(negedge clk);
    #1;
    chk("overrun_single_ready", 32'(sbq.size()), 32'd0);
    chk("overrun_idle", 32'(bus.busy), 32'd0);

    // Conflict leaves memory untouched
    access(1'b1, 1'b1, 16'h0010, 16'h0000);
    access(1'b1, 1'b0, 16'h0010, 16'h0000);

    // Reset mid-access aborts a pending write
    access(1'b0, 1'b1, 16'h0005, 16'h5555);
    bus.DRAM_write = 1'b1;
    bus.addr       = 16'h0005;
    bus.wdata      = 16'h1234;
    @(posedge clk); @(negedge clk);
    bus.DRAM_write = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk_reset_state();
    repeat (4) @(negedge clk);
    chk("abort_no_ready_pending", 32'(sbq.size()), 32'd0);

    // Address boundaries and rdata hold
    access(1'b0, 1'b1, 16'hFFFF, 16'hCAFE);
    access(1'b0, 1'b1, 16'h0000, 16'h0A0A);
    access(1'b1, 1'b0, 16'hFFFF, 16'h0000);
    repeat (3) @(negedge clk);
    chk("rdata_hold", 32'(bus.rdata), 32'h0000_CAFE);
    access(1'b1, 1'b0, 16'h0000, 16'h0000);
    access(1'b1, 1'b0, 16'h0005, 16'h0000);
    access(1'b1, 1'b1, 16'h0000, 16'hFFFF);
    chk("no_overrun_after_reset", 32'(bus.err_overrun), 32'd0);
`ifdef DRAM_STATS_EN
    chk("rd_count", 32'(bus.rd_count), 32'd3);
    chk("wr_count", 32'(bus.wr_count), 32'd2);
`endif

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
